// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/load-store memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_LOAD  = 2'd2;

  // Memory strobes are active low.
  localparam logic MEM_ON  = 1'b0;
  localparam logic MEM_OFF = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; flags when fetch must win.
module mem_port_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_fetch_req,
  input  logic i_fetch_ack,
  output logic o_starved
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;

  // Frozen while disabled so a paused core does not lose its accumulated wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_fetch_ack || !i_fetch_req) begin
        r_cnt <= '0;
      end else if (r_cnt < LP_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_starved = (r_cnt >= LP_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store; data-first with a
// fetch starvation guard, one-cycle read return, and a drain-to-idle halt sequence.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              halt_req,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_wen,
  output logic              mem_oen,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              idle
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [1:0] r_owner;
  logic [1:0] w_owner_nxt;
  logic       w_live;
  logic       w_fetch_ok;
  logic       w_data_ok;
  logic       w_starved;
  logic       w_gnt_i;
  logic       w_gnt_d;

  mem_port_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (en),
    .i_fetch_req (i_req),
    .i_fetch_ack (w_gnt_i),
    .o_starved   (w_starved)
  );

  // Grants are combinational, so reset gates them to keep the memory quiet
  // while rst_n is low.
  assign w_live     = rst_n & en;
  assign w_fetch_ok = w_live && (r_state == ST_RUN) && !halt_req;
  assign w_data_ok  = w_live && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_gnt_i    = w_fetch_ok && i_req && (!d_req || w_starved);
  assign w_gnt_d    = w_data_ok && d_req && !w_gnt_i;

  assign i_ack = w_gnt_i;
  assign d_ack = w_gnt_d;

  always_comb begin
    mem_addr    = '0;
    mem_datain  = '0;
    mem_wen     = MEM_OFF;
    mem_oen     = MEM_OFF;
    w_owner_nxt = OWN_NONE;
    if (w_gnt_i) begin
      mem_addr    = i_addr;
      mem_oen     = MEM_ON;
      w_owner_nxt = OWN_FETCH;
    end else if (w_gnt_d) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_datain = d_wdata;
        mem_wen    = MEM_ON;
      end else begin
        mem_oen     = MEM_ON;
        w_owner_nxt = OWN_LOAD;
      end
    end
  end

  // Leave DRAIN once nothing is requested and nothing will be returned next
  // cycle, so HALTED follows directly after the last rvalid.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (halt_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!d_req && (w_owner_nxt == OWN_NONE)) w_state_nxt = ST_HALTED;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_owner <= OWN_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  assign i_rvalid = (r_owner == OWN_FETCH);
  assign d_rvalid = (r_owner == OWN_LOAD);
  assign i_rdata  = i_rvalid ? mem_dataout : '0;
  assign d_rdata  = d_rvalid ? mem_dataout : '0;
  assign idle     = (r_state == ST_HALTED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus queues expected grants and read returns, a negedge monitor checks them.
module tb_mem_port_arbiter;

  typedef struct {
    int          cyc;
    int          kind;   // 0 fetch, 1 load, 2 store
    logic [31:0] addr;
    logic [31:0] dat;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        halt_req = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        i_ack, i_rvalid, d_ack, d_rvalid, mem_wen, mem_oen, idle;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_datain;
  logic [31:0] mem_dataout = '0;
  logic [31:0] mem_arr [0:255];

  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  c;
  ev_t gq[$];
  ev_t rq[$];

  mem_port_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .halt_req    (halt_req),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ack       (i_ack),
    .i_rvalid    (i_rvalid),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_wen     (mem_wen),
    .mem_oen     (mem_oen),
    .mem_dataout (mem_dataout),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous memory model.
  always @(posedge clk) begin
    if (!mem_wen) mem_arr[mem_addr[7:0]] <= mem_datain;
    if (!mem_oen) mem_dataout <= mem_arr[mem_addr[7:0]];
  end

  task automatic chk(input bit ok, input string name, input string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(input int cy, input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.cyc = cy; e.kind = k; e.addr = a; e.dat = d;
    gq.push_back(e);
  endtask

  task automatic push_r(input int cy, input int k, input logic [31:0] d);
    ev_t e;
    e.cyc = cy; e.kind = k; e.addr = '0; e.dat = d;
    rq.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t         e;
    int          k;
    logic        x_oen, x_wen;
    logic [31:0] x_din, a_dat, a_oth;
    if (i_ack || d_ack) begin
      k = i_ack ? 0 : (d_we ? 2 : 1);
      if (i_ack && d_ack) begin
        chk(1'b0, "grant_dual", $sformatf("cyc=%0d got i_ack=1 d_ack=1 want at most one", cyc));
      end else if (gq.size() == 0) begin
        chk(1'b0, "grant_unexp", $sformatf("cyc=%0d got kind=%0d addr=%h want no grant", cyc, k, mem_addr));
      end else begin
        e = gq.pop_front();
        x_oen = (e.kind == 2);
        x_wen = (e.kind != 2);
        x_din = (e.kind == 2) ? e.dat : 32'h0;
        chk(cyc == e.cyc && k == e.kind && mem_addr == e.addr && mem_oen == x_oen &&
            mem_wen == x_wen && mem_datain == x_din, "grant",
            $sformatf("got cyc=%0d kind=%0d addr=%h oen=%b wen=%b din=%h want cyc=%0d kind=%0d addr=%h oen=%b wen=%b din=%h",
                      cyc, k, mem_addr, mem_oen, mem_wen, mem_datain,
                      e.cyc, e.kind, e.addr, x_oen, x_wen, x_din));
      end
    end else begin
      chk(mem_wen && mem_oen && mem_addr == 0 && mem_datain == 0, "mem_idle",
          $sformatf("cyc=%0d got wen=%b oen=%b addr=%h din=%h want 1 1 0 0",
                    cyc, mem_wen, mem_oen, mem_addr, mem_datain));
    end

    if (i_rvalid || d_rvalid) begin
      k     = i_rvalid ? 0 : 1;
      a_dat = i_rvalid ? i_rdata : d_rdata;
      a_oth = i_rvalid ? d_rdata : i_rdata;
      if (i_rvalid && d_rvalid) begin
        chk(1'b0, "rvalid_dual", $sformatf("cyc=%0d got both rvalid want one", cyc));
      end else if (rq.size() == 0) begin
        chk(1'b0, "rvalid_unexp", $sformatf("cyc=%0d got kind=%0d data=%h want none", cyc, k, a_dat));
      end else begin
        e = rq.pop_front();
        chk(cyc == e.cyc && k == e.kind && a_dat == e.dat && a_oth == 0, "rvalid",
            $sformatf("got cyc=%0d kind=%0d data=%h other=%h want cyc=%0d kind=%0d data=%h other=0",
                      cyc, k, a_dat, a_oth, e.cyc, e.kind, e.dat));
      end
    end else begin
      chk(i_rdata == 0 && d_rdata == 0, "rdata_idle",
          $sformatf("cyc=%0d got i_rdata=%h d_rdata=%h want 0 0", cyc, i_rdata, d_rdata));
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    mem_arr[8'h10] = 32'hDEADBEEF;
    mem_arr[8'h20] = 32'hCAFE0020;
    mem_arr[8'h24] = 32'h11112222;
    mem_arr[8'h30] = 32'h30303030;
    mem_arr[8'h34] = 32'h34343434;
    mem_arr[8'h50] = 32'h50505050;

    // Reset holds everything quiet even with a live request and en high.
    en = 1'b1; i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    chk(!i_ack && !d_ack && !i_rvalid && !d_rvalid && !idle && mem_oen && mem_wen &&
        mem_addr == 0 && mem_datain == 0, "reset_state",
        $sformatf("got ia=%b da=%b irv=%b drv=%b idle=%b oen=%b wen=%b addr=%h want all inactive",
                  i_ack, d_ack, i_rvalid, d_rvalid, idle, mem_oen, mem_wen, mem_addr));
    step(); i_req = 1'b0; rst_n = 1'b1;
    step();

    // Fetch only.
    step(); c = cyc; i_req = 1'b1; i_addr = 32'h10;
    push_g(c, 0, 32'h10, 0); push_r(c + 1, 0, 32'hDEADBEEF);
    step(); i_req = 1'b0;
    step(); step();

    // Data wins a tie, fetch follows.
    step(); c = cyc; i_req = 1'b1; i_addr = 32'h24; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    push_g(c, 1, 32'h20, 0); push_g(c + 1, 0, 32'h24, 0);
    push_r(c + 1, 1, 32'hCAFE0020); push_r(c + 2, 0, 32'h11112222);
    step(); d_req = 1'b0;
    step(); i_req = 1'b0;
    step();

    // Starvation guard: fetch gets the fifth contested cycle.
    step(); c = cyc; d_req = 1'b1; d_addr = 32'h30; i_req = 1'b1; i_addr = 32'h34;
    for (int j = 0; j < 10; j++) begin
      if (j == 4) push_g(c + j, 0, 32'h34, 0);
      else        push_g(c + j, 1, 32'h30, 0);
      push_r(c + j + 1, (j == 4) ? 0 : 1, (j == 4) ? 32'h34343434 : 32'h30303030);
    end
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 5) i_req = 1'b0;
      if (j == 10) d_req = 1'b0;
    end
    step();

    // Store then load the same word.
    step(); c = cyc; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
    push_g(c, 2, 32'h40, 32'h1234);
    step(); d_we = 1'b0;
    push_g(c + 1, 1, 32'h40, 0); push_r(c + 2, 1, 32'h1234);
    step(); d_req = 1'b0; d_wdata = '0;
    step();

    // en drop: issued read still returns, nothing new granted until en returns.
    step(); c = cyc; i_req = 1'b1; i_addr = 32'h24;
    push_g(c, 0, 32'h24, 0); push_r(c + 1, 0, 32'h11112222);
    step(); en = 1'b0; i_addr = 32'h10;
    step();
    step(); en = 1'b1;
    push_g(c + 3, 0, 32'h10, 0); push_r(c + 4, 0, 32'hDEADBEEF);
    step(); i_req = 1'b0;
    step();

    // Reset one cycle after a fetch ack discards the response.
    step(); c = cyc; i_req = 1'b1; i_addr = 32'h10;
    push_g(c, 0, 32'h10, 0);
    step(); rst_n = 1'b0; i_req = 1'b0;
    @(negedge clk);
    chk(!i_rvalid && !i_ack && mem_oen && mem_wen && !idle && i_rdata == 0, "reset_mid_read",
        $sformatf("got irv=%b ia=%b oen=%b wen=%b idle=%b rdata=%h want 0 0 1 1 0 0",
                  i_rvalid, i_ack, mem_oen, mem_wen, idle, i_rdata));
    step(); rst_n = 1'b1;
    step(); c = cyc; i_req = 1'b1; i_addr = 32'h24;
    push_g(c, 0, 32'h24, 0); push_r(c + 1, 0, 32'h11112222);
    step(); i_req = 1'b0;
    step();

    // Halt with a load pending: load completes, fetch never acked, then idle.
    step(); c = cyc; halt_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
    i_req = 1'b1; i_addr = 32'h10;
    push_g(c, 1, 32'h50, 0); push_r(c + 1, 1, 32'h50505050);
    step(); d_req = 1'b0;
    @(negedge clk);
    chk(!idle, "idle_drain", $sformatf("got idle=%b want 0", idle));
    step();
    @(negedge clk);
    chk(idle, "idle_halted", $sformatf("got idle=%b want 1", idle));
    step(); halt_req = 1'b0;
    step(); d_req = 1'b1; d_addr = 32'h20;
    @(negedge clk);
    chk(idle && !i_ack && !d_ack, "halted_hold",
        $sformatf("got idle=%b ia=%b da=%b want 1 0 0", idle, i_ack, d_ack));
    step(); d_req = 1'b0; i_req = 1'b0;
    step();

    chk(gq.size() == 0 && rq.size() == 0, "sb_drain",
        $sformatf("got %0d grants %0d returns outstanding want 0 0", gq.size(), rq.size()));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
